// File: rtl/imem_prog_encoder.sv
// Packs per-instruction field bundles into 32-bit MIPS words and streams them
// into consecutive instruction-memory words starting at BASE_ADDR.
module imem_prog_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overflow
);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    localparam logic [2:0] K_RTYPE = 3'd0;
    localparam logic [2:0] K_LW    = 3'd1;
    localparam logic [2:0] K_SW    = 3'd2;
    localparam logic [2:0] K_BEQ   = 3'd3;
    localparam logic [2:0] K_ADDI  = 3'd4;
    localparam logic [2:0] K_J     = 3'd5;
    localparam logic [2:0] K_ORI   = 3'd6;
    localparam logic [2:0] K_BNE   = 3'd7;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state;
    logic        last_q;
    logic [31:0] enc;

    // Immediate is copied bit-exact; fields a kind does not use are dropped.
    always_comb begin
        enc = 32'h0;
        case (in_kind)
            K_RTYPE: enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            K_LW:    enc = {6'b100011, in_rs, in_rt, in_imm};
            K_SW:    enc = {6'b101011, in_rs, in_rt, in_imm};
            K_BEQ:   enc = {6'b000100, in_rs, in_rt, in_imm};
            K_ADDI:  enc = {6'b001000, in_rs, in_rt, in_imm};
            K_J:     enc = {6'b000010, in_target};
            K_ORI:   enc = {6'b001101, in_rs, in_rt, in_imm};
            K_BNE:   enc = {6'b000101, in_rs, in_rt, in_imm};
            default: enc = 32'h0;
        endcase
    end

    // Handshake outputs are pure state decodes, so no input reaches an output.
    assign in_ready = (state == IDLE);
    assign imem_we  = (state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_q    <= 1'b0;
            imem_addr <= BASE;
            imem_wd   <= 32'h0;
            count     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        imem_wd <= enc;
                        last_q  <= in_last;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    count <= count + (ADDR_W+1)'(1);
                    if (last_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (imem_addr == TOP_ADDR) begin
                        done     <= 1'b1;
                        overflow <= 1'b1;
                        state    <= DONE;
                    end else begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        state     <= IDLE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_prog_encoder.sv
// Directed bench for imem_prog_encoder: a default-size instance plus a 4-word
// instance used to exercise memory overflow.
module tb_imem_prog_encoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        in_ready, imem_we, done, overflow;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;
    logic [6:0]  count;

    logic        rdy2, we2, done2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_prog_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wd(imem_wd), .count(count),
        .done(done), .overflow(overflow)
    );

    imem_prog_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we2),
        .imem_addr(addr2), .imem_wd(wd2), .count(cnt2),
        .done(done2), .overflow(ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_bundle(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0);
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", imem_we); end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL reset_addr got %0d exp 0", imem_addr); end
        tests++; if (imem_wd !== 32'h0) begin fails++; $display("FAIL reset_wd got %h exp 0", imem_wd); end
        tests++; if (count !== 7'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if ({done, overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {done, overflow}); end
    endtask

    task automatic test_addi();
        do_reset();
        set_bundle(3'd4, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (imem_we !== 1'b1) begin fails++; $display("FAIL addi_we got %b exp 1", imem_we); end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL addi_addr got %0d exp 0", imem_addr); end
        tests++; if (imem_wd !== 32'h20020005) begin fails++; $display("FAIL addi_wd got %h exp 20020005", imem_wd); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL addi_busy got %b exp 0", in_ready); end
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL addi_ready got %b exp 1", in_ready); end
        tests++; if (count !== 7'd1) begin fails++; $display("FAIL addi_count got %0d exp 1", count); end
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL addi_we_off got %b exp 0", imem_we); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_wd [3];
        int writes;
        exp_wd[0] = 32'h00221820; exp_wd[1] = 32'h8FA80004; exp_wd[2] = 32'h08000010;
        writes = 0;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_bundle(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
                1: set_bundle(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
                default: set_bundle(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
            endcase
            tick();
            if (imem_we === 1'b1) writes++;
            tests++; if (imem_addr !== 6'(i)) begin fails++; $display("FAIL b2b_addr%0d got %0d exp %0d", i, imem_addr, i); end
            tests++; if (imem_wd !== exp_wd[i]) begin fails++; $display("FAIL b2b_wd%0d got %h exp %h", i, imem_wd, exp_wd[i]); end
            tick();
            if (imem_we === 1'b1) writes++;
            tests++; if (count !== 7'(i + 1)) begin fails++; $display("FAIL b2b_count%0d got %0d exp %0d", i, count, i + 1); end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b exp 1", done); end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (imem_we === 1'b1) writes++;
        end
        in_valid = 1'b0;
        tests++; if (writes !== 3) begin fails++; $display("FAIL b2b_writes got %0d exp 3", writes); end
        tests++; if (count !== 7'd3) begin fails++; $display("FAIL b2b_count_end got %0d exp 3", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_imm_passthrough();
        logic [31:0] exp_wd [3];
        exp_wd[0] = 32'h1022FFFF; exp_wd[1] = 32'h340400FF; exp_wd[2] = 32'h1422FFFE;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            // Unused rd/shamt/funct/target are driven non-zero to prove they are ignored.
            case (i)
                0: set_bundle(3'd3, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
                1: set_bundle(3'd6, 5'd0, 5'd4, 5'd31, 5'd31, 6'h3F, 16'h00FF, 26'h3FFFFFF, 1'b0);
                default: set_bundle(3'd7, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFE, 26'h3FFFFFF, 1'b1);
            endcase
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tests++; if (imem_wd !== exp_wd[i]) begin fails++; $display("FAIL imm_wd%0d got %h exp %h", i, imem_wd, exp_wd[i]); end
            tick();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_bundle(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, 1'b0);
            in_valid = 1'b1;
            tick();
            tests++; if ({we2, addr2} !== {1'b1, 2'(i)}) begin fails++; $display("FAIL ovf_addr%0d got we=%b addr=%0d exp we=1 addr=%0d", i, we2, addr2, i); end
            tests++; if (wd2 !== (32'h20210000 | 32'(i))) begin fails++; $display("FAIL ovf_wd%0d got %h exp %h", i, wd2, 32'h20210000 | 32'(i)); end
            tick();
        end
        tests++; if ({done2, ovf2} !== 2'b11) begin fails++; $display("FAIL ovf_flags got %b exp 11", {done2, ovf2}); end
        tests++; if (cnt2 !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", cnt2); end
        tests++; if (rdy2 !== 1'b0) begin fails++; $display("FAIL ovf_ready got %b exp 0", rdy2); end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (we2 !== 1'b0) begin fails++; $display("FAIL ovf_extra_we got %b exp 0", we2); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        set_bundle(3'd4, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0011, 26'h0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        set_bundle(3'd4, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0022, 26'h0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if ({imem_we, imem_addr} !== {1'b1, 6'd1}) begin fails++; $display("FAIL rmw_second got we=%b addr=%0d exp we=1 addr=1", imem_we, imem_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL rmw_we got %b exp 0", imem_we); end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL rmw_addr got %0d exp 0", imem_addr); end
        tests++; if (count !== 7'd0) begin fails++; $display("FAIL rmw_count got %0d exp 0", count); end
        tests++; if ({done, in_ready} !== 2'b01) begin fails++; $display("FAIL rmw_state got done,ready=%b exp 01", {done, in_ready}); end
        set_bundle(3'd4, 5'd0, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0033, 26'h0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if ({imem_we, imem_addr, imem_wd} !== {1'b1, 6'd0, 32'h20060033}) begin fails++; $display("FAIL rmw_rewrite got we=%b addr=%0d wd=%h exp we=1 addr=0 wd=20060033", imem_we, imem_addr, imem_wd); end
        tick();
    endtask

    task automatic test_done_sticky();
        do_reset();
        set_bundle(3'd2, 5'd4, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0008, 26'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        tests++; if (imem_wd !== 32'hAC890008) begin fails++; $display("FAIL sticky_sw_wd got %h exp ac890008", imem_wd); end
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL sticky_done got %b exp 1", done); end
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL sticky_we%0d got %b exp 0", c, imem_we); end
        end
        in_valid = 1'b0;
        tests++; if ({count, done} !== {7'd1, 1'b1}) begin fails++; $display("FAIL sticky_count got count=%0d done=%b exp count=1 done=1", count, done); end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_imm_passthrough();
        test_overflow();
        test_reset_mid_write();
        test_done_sticky();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
